// File: rtl/aes_key_schedule_if.sv
// Key-load and round-key read bus of the AES key-expansion engine.
// master drives keys and read requests; slave is the key schedule itself.
interface aes_key_schedule_if #(
  parameter int unsigned KEY_BITS = 128
);
  logic [KEY_BITS-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic                busy;
  logic                keys_ready;
  logic                rk_req;
  logic [3:0]          rk_idx;
  logic                rk_dec;
  logic                rk_valid;
  logic [127:0]        rk_out;
  logic                rk_err;

  modport master (
    output key_in, key_valid, rk_req, rk_idx, rk_dec,
    input  key_ready, busy, keys_ready, rk_valid, rk_out, rk_err
  );

  modport slave (
    input  key_in, key_valid, rk_req, rk_idx, rk_dec,
    output key_ready, busy, keys_ready, rk_valid, rk_out, rk_err
  );
endinterface

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Purely combinational; the inverse is formed as x^254.
module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] pw;
  logic [7:0] inv;

  always_comb begin
    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally
    pw  = din;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    dout = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end
endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion (one word per clock) into a round-key store,
// with a one-cycle-latency read port serving forward or inverse round order.
module aes_key_schedule #(
  parameter int unsigned KEY_BITS = 128
) (
  input logic          clk,
  input logic          rst_n,
  aes_key_schedule_if.slave bus
);
  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] NW_LAST = 6'(NW - 1);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_W    = 4'(NR);

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  state_e       state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   pos_q, pos_d;     // i mod Nk, tracked incrementally
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  w_q [NW];

  logic         accept;
  logic [31:0]  prev_w, old_w, sub_in, sub_out, t_w, new_w;
  logic         rd_hit, rd_oob;
  logic [3:0]   rd_round;
  logic [5:0]   rd_base;
  logic [127:0] rd_word;
  logic         rk_valid_q, rk_err_q;
  logic [127:0] rk_out_q;

  assign accept = bus.key_valid && (state_q != StExpand);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StExpand;
      StExpand: if (i_q == NW_LAST) state_d = StReady;
      StReady:  if (accept) state_d = StExpand;
      default:  state_d = StIdle;
    endcase
  end

  assign bus.key_ready  = (state_q != StExpand);
  assign bus.busy       = (state_q == StExpand);
  assign bus.keys_ready = (state_q == StReady);

  assign prev_w = w_q[i_q - 6'd1];
  assign old_w  = w_q[i_q - NK_W];
  assign sub_in = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    t_w = prev_w;
    if (pos_q == 3'd0) begin
      t_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && pos_q == 3'd4) begin
      t_w = sub_out;
    end
  end

  assign new_w = old_w ^ t_w;

  always_comb begin
    i_d    = i_q;
    pos_d  = pos_q;
    rcon_d = rcon_q;
    if (accept) begin
      i_d    = NK_W;
      pos_d  = 3'd0;
      rcon_d = 8'h01;
    end else if (state_q == StExpand) begin
      i_d   = i_q + 6'd1;
      pos_d = (pos_q == NK_LAST) ? 3'd0 : pos_q + 3'd1;
      if (pos_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  // Reads use the pre-edge store, so a read colliding with a reload sees the old schedule.
  assign rd_hit   = bus.rk_req && (state_q == StReady);
  assign rd_oob   = (bus.rk_idx > NR_W);
  assign rd_round = bus.rk_dec ? (NR_W - bus.rk_idx) : bus.rk_idx;
  assign rd_base  = {rd_round, 2'b00};
  assign rd_word  = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      i_q        <= '0;
      pos_q      <= '0;
      rcon_q     <= '0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      pos_q      <= pos_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rd_hit;
      rk_err_q   <= rd_hit && rd_oob;
      if (rd_hit) rk_out_q <= rd_oob ? '0 : rd_word;
    end
  end

  // Store has no reset: its contents are meaningless until a schedule completes.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NK; k++) begin
        w_q[k] <= bus.key_in[KEY_BITS-1-32*k -: 32];
      end
    end else if (state_q == StExpand) begin
      w_q[i_q] <= new_w;
    end
  end

  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_err   = rk_err_q;
  assign bus.rk_out   = rk_out_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: three instances (128/192/256) checked every cycle
// against an array-based FIPS-197 expansion model, plus known-answer vectors.
module tb_aes_key_schedule;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key;
  logic [2:0]   kv, rq;
  logic [3:0]   rk_idx;
  logic         rk_dec;
  logic [2:0]   kry, bsy, krd, rv, re;
  logic [127:0] ro [3];

  always #5 clk = ~clk;

  aes_key_schedule_if #(.KEY_BITS(128)) if0 ();
  aes_key_schedule_if #(.KEY_BITS(192)) if1 ();
  aes_key_schedule_if #(.KEY_BITS(256)) if2 ();

  assign if0.key_in = key[255 -: 128];
  assign if1.key_in = key[255 -: 192];
  assign if2.key_in = key;
  assign if0.key_valid = kv[0];
  assign if1.key_valid = kv[1];
  assign if2.key_valid = kv[2];
  assign if0.rk_req = rq[0];
  assign if1.rk_req = rq[1];
  assign if2.rk_req = rq[2];
  assign if0.rk_idx = rk_idx;
  assign if1.rk_idx = rk_idx;
  assign if2.rk_idx = rk_idx;
  assign if0.rk_dec = rk_dec;
  assign if1.rk_dec = rk_dec;
  assign if2.rk_dec = rk_dec;

  assign kry = {if2.key_ready, if1.key_ready, if0.key_ready};
  assign bsy = {if2.busy, if1.busy, if0.busy};
  assign krd = {if2.keys_ready, if1.keys_ready, if0.keys_ready};
  assign rv  = {if2.rk_valid, if1.rk_valid, if0.rk_valid};
  assign re  = {if2.rk_err, if1.rk_err, if0.rk_err};
  assign ro[0] = if0.rk_out;
  assign ro[1] = if1.rk_out;
  assign ro[2] = if2.rk_out;

  aes_key_schedule #(.KEY_BITS(128)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  aes_key_schedule #(.KEY_BITS(192)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  aes_key_schedule #(.KEY_BITS(256)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: phase 0 idle, 1 expanding, 2 ready
  logic [7:0]   sb [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int           m_phase [3];
  int           m_cnt [3];
  logic         m_rv [3];
  logic         m_re [3];
  logic [127:0] m_ro [3];
  logic [31:0]  m_sched [3][60];

  task automatic check(input string name, input int s, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h expected %h", name, s, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] c = 8'h63;
    logic [7:0] inv;
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        v[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = v;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input int s, input logic [255:0] k);
    int nk = 4 + 2 * s;
    int nw = 4 * (nk + 7);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) m_sched[s][i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = m_sched[s][i-1];
      if (i % nk == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subword(t);
      m_sched[s][i] = m_sched[s][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] round_key(input int s, input int r);
    return {m_sched[s][4*r], m_sched[s][4*r+1], m_sched[s][4*r+2], m_sched[s][4*r+3]};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_phase[s] = 0;
      m_cnt[s]   = 0;
      m_rv[s]    = 1'b0;
      m_re[s]    = 1'b0;
      m_ro[s]    = '0;
    end
  endtask

  // Applies the inputs that were present at the clock edge just taken.
  task automatic model_step();
    int nk, nr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int s = 0; s < 3; s++) begin
      nk = 4 + 2 * s;
      nr = nk + 6;
      m_rv[s] = 1'b0;
      m_re[s] = 1'b0;
      if (m_phase[s] == 2 && rq[s]) begin
        m_rv[s] = 1'b1;
        if (int'(rk_idx) > nr) begin
          m_re[s] = 1'b1;
          m_ro[s] = '0;
        end else begin
          m_ro[s] = round_key(s, rk_dec ? nr - int'(rk_idx) : int'(rk_idx));
        end
      end
      if (m_phase[s] != 1 && kv[s]) begin
        expand(s, key);
        m_phase[s] = 1;
        m_cnt[s]   = 4 * (nr + 1) - nk;
      end else if (m_phase[s] == 1) begin
        m_cnt[s]--;
        if (m_cnt[s] == 0) m_phase[s] = 2;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 3; s++) begin
        check("key_ready", s, 128'(kry[s]), 128'(m_phase[s] != 1));
        check("busy", s, 128'(bsy[s]), 128'(m_phase[s] == 1));
        check("keys_ready", s, 128'(krd[s]), 128'(m_phase[s] == 2));
        check("rk_valid", s, 128'(rv[s]), 128'(m_rv[s]));
        check("rk_err", s, 128'(re[s]), 128'(m_re[s]));
        check("rk_out", s, ro[s], m_ro[s]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load(input int s, input logic [255:0] k);
    key   = k;
    kv[s] = 1'b1;
    tick();
    kv[s] = 1'b0;
  endtask

  task automatic wait_ready(input int s, input int done, input int exp);
    int c = done;
    while (!krd[s] && c < 200) begin
      tick();
      c++;
    end
    check("ready_latency", s, 128'(c), 128'(exp));
  endtask

  task automatic read(input int s, input int idx, input logic dec);
    rq[s]  = 1'b1;
    rk_idx = 4'(idx);
    rk_dec = dec;
    tick();
    rq[s]  = 1'b0;
  endtask

  task automatic rand_reads(input int s, input int n);
    for (int j = 0; j < n; j++) begin
      rq[s]  = ($urandom_range(0, 3) != 0);
      rk_idx = 4'($urandom_range(0, 15));
      rk_dec = 1'($urandom_range(0, 1));
      tick();
    end
    rq[s] = 1'b0;
    tick();
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    key    = '0;
    kv     = '0;
    rq     = '0;
    rk_idx = '0;
    rk_dec = 1'b0;
    build_sbox();

    // Pin the model itself against known-answer vectors
    expand(0, K128);
    check("model_128_r1", 0, round_key(0, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_128_r10", 0, round_key(0, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expand(1, K192);
    check("model_192_r12", 1, round_key(1, 12), 128'he98ba06f448c773c8ecc720401002202);
    expand(2, K256);
    check("model_256_r14", 2, round_key(2, 14), 128'hfe4890d1e6188d0b046df344706c631e);
    model_reset();

    tick();
    tick();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    check("rst_key_ready", 0, 128'(kry[0]), 128'd1);
    check("rst_busy", 0, 128'(bsy[0]), 128'd0);
    check("rst_keys_ready", 0, 128'(krd[0]), 128'd0);
    check("rst_rk_out", 0, ro[0], 128'd0);

    // AES-128, with reads and a key offered while expanding
    load(0, K128);
    repeat (5) tick();
    rq[0]  = 1'b1;
    rk_idx = 4'd3;
    tick();
    check("req_in_expand", 0, 128'(rv[0]), 128'd0);
    tick();
    rq[0] = 1'b0;
    key   = rand_key();
    kv[0] = 1'b1;
    tick();
    kv[0] = 1'b0;
    wait_ready(0, 8, 40);
    read(0, 1, 1'b0);
    check("kat128_r1", 0, ro[0], 128'ha0fafe1788542cb123a339392a6c7605);
    check("kat128_r1_valid", 0, 128'(rv[0]), 128'd1);
    read(0, 0, 1'b1);
    check("kat128_dec0", 0, ro[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read(0, 11, 1'b0);
    check("oob_valid", 0, 128'(rv[0]), 128'd1);
    check("oob_err", 0, 128'(re[0]), 128'd1);
    check("oob_out", 0, ro[0], 128'd0);
    tick();
    check("oob_pulse", 0, 128'(re[0]), 128'd0);
    rand_reads(0, 40);

    // Reload colliding with a read of round 10 of the old schedule
    key    = rand_key();
    kv[0]  = 1'b1;
    rq[0]  = 1'b1;
    rk_idx = 4'd10;
    rk_dec = 1'b0;
    tick();
    kv[0]  = 1'b0;
    rq[0]  = 1'b0;
    check("collide_out", 0, ro[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("collide_keys_ready", 0, 128'(krd[0]), 128'd0);
    wait_ready(0, 0, 40);
    rand_reads(0, 40);

    // Reset in the middle of an expansion
    load(0, rand_key());
    repeat (20) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_key_ready", 0, 128'(kry[0]), 128'd1);
    check("midrst_busy", 0, 128'(bsy[0]), 128'd0);
    check("midrst_keys_ready", 0, 128'(krd[0]), 128'd0);
    check("midrst_rk_out", 0, ro[0], 128'd0);
    tick();
    rst_n = 1'b1;
    load(0, K128);
    wait_ready(0, 0, 40);
    read(0, 1, 1'b0);
    check("postrst_r1", 0, ro[0], 128'ha0fafe1788542cb123a339392a6c7605);

    // AES-192
    load(1, K192);
    wait_ready(1, 0, 46);
    read(1, 12, 1'b0);
    check("kat192_r12", 1, ro[1], 128'he98ba06f448c773c8ecc720401002202);
    read(1, 0, 1'b1);
    check("kat192_dec0", 1, ro[1], 128'he98ba06f448c773c8ecc720401002202);
    rand_reads(1, 40);

    // AES-256
    load(2, K256);
    wait_ready(2, 0, 52);
    read(2, 14, 1'b0);
    check("kat256_r14", 2, ro[2], 128'hfe4890d1e6188d0b046df344706c631e);
    read(2, 0, 1'b0);
    check("kat256_r0", 2, ro[2], 128'h603deb1015ca71be2b73aef0857d7781);
    rand_reads(2, 40);

    // Random keys on every key size
    for (int rep = 0; rep < 3; rep++) begin
      for (int s = 0; s < 3; s++) begin
        load(s, rand_key());
        wait_ready(s, 0, 4 * (11 + 2 * s) - (4 + 2 * s));
        rand_reads(s, 20);
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
